// File: rtl/sdram_block_sink.sv
// Collects one WORDS-long block from a FIFO read side into a local buffer,
// then writes it to SDRAM at consecutive word addresses starting at base.
module sdram_block_sink #(
    parameter int WORDS  = 512,
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_tx_rdy,
    output logic              sdram_rx_rdy,
    input  logic              fifo_rdreq,
    input  logic [15:0]       fifo_q,
    output logic              sd_wr_req,
    output logic [ADDR_W-1:0] sd_wr_addr,
    output logic [15:0]       sd_wr_data,
    input  logic              sd_wr_ack,
    output logic              blk_done,
    output logic              err
);
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

    state_t            state_q, state_d;
    logic              rdreq_dly_q;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rx_rdy_q, rx_rdy_d;
    logic              mem_we;

    logic [15:0] buf_mem [WORDS];

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        base_d   = base_q;
        req_d    = req_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = err_q;
        rx_rdy_d = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_tx_rdy) begin
                    state_d  = REQ;
                    rx_rdy_d = 1'b1;
                end
            end
            REQ: state_d = RECV;
            RECV: begin
                if (rdreq_dly_q) begin
                    mem_we = 1'b1;
                    if (wcnt_q == LAST) begin
                        wcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                // One idle cycle after each ack lets the next word load from
                // the buffer into the registered data/address outputs.
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = base_q + ADDR_W'(rcnt_q);
                    data_d = buf_mem[rcnt_q];
                end else if (sd_wr_ack) begin
                    req_d = 1'b0;
                    if (rcnt_q == LAST) begin
                        rcnt_d  = '0;
                        base_d  = base_q + ADDR_W'(WORDS);
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A read strobe outside RECV is an overrun; the word is dropped.
        if (rdreq_dly_q && state_q != RECV)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdreq_dly_q <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            base_q      <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rx_rdy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdreq_dly_q <= fifo_rdreq;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            base_q      <= base_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rx_rdy_q    <= rx_rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            buf_mem[wcnt_q] <= fifo_q;
    end

    assign sdram_rx_rdy = rx_rdy_q;
    assign sd_wr_req    = req_q;
    assign sd_wr_addr   = addr_q;
    assign sd_wr_data   = data_q;
    assign blk_done     = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_sdram_block_sink.sv
// Directed bench: FIFO source, SDRAM ack model with optional stalls, and a
// write log checked block by block against hand-derived addresses and data.
module tb_sdram_block_sink;
    localparam int WORDS  = 512;
    localparam int ADDR_W = 10;
    localparam int LOG_N  = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_tx_rdy = 1'b0;
    logic              sdram_rx_rdy;
    logic              fifo_rdreq = 1'b0;
    logic [15:0]       fifo_q = '0;
    logic              sd_wr_req;
    logic [ADDR_W-1:0] sd_wr_addr;
    logic [15:0]       sd_wr_data;
    logic              sd_wr_ack = 1'b0;
    logic              blk_done;
    logic              err;

    int checks = 0;
    int failures = 0;

    int ack_mode = 0;
    int stall = 0;
    int wr_cnt = 0;
    int stab_err = 0;
    int done_cnt = 0;
    int rx_cnt = 0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] p_addr;
    logic [15:0]       p_data;
    logic [ADDR_W-1:0] log_addr [LOG_N];
    logic [15:0]       log_data [LOG_N];

    sdram_block_sink #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .fifo_tx_rdy(fifo_tx_rdy), .sdram_rx_rdy(sdram_rx_rdy),
        .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .sd_wr_req(sd_wr_req),
        .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_ack(sd_wr_ack),
        .blk_done(blk_done), .err(err)
    );

    always #5 clk = ~clk;

    // SDRAM model: outputs are stable from the posedge to the next, so each
    // negedge sees what the next posedge samples together with the ack set here.
    always @(negedge clk) begin
        logic ack_n;
        if (rst) begin
            pend = 1'b0;
            sd_wr_ack = 1'b0;
        end else begin
            if (pend && !(sd_wr_req === 1'b1 && sd_wr_addr === p_addr && sd_wr_data === p_data))
                stab_err++;
            if (ack_mode == 0) begin
                ack_n = 1'b1;
            end else if (sd_wr_req) begin
                if (stall == 0) begin
                    ack_n = 1'b1;
                    stall = $urandom_range(0, 5);
                end else begin
                    ack_n = 1'b0;
                    stall--;
                end
            end else begin
                ack_n = 1'($urandom_range(0, 1));
            end
            sd_wr_ack = ack_n;
            if (sd_wr_req && ack_n) begin
                if (wr_cnt < LOG_N) begin
                    log_addr[wr_cnt] = sd_wr_addr;
                    log_data[wr_cnt] = sd_wr_data;
                end
                wr_cnt++;
                pend = 1'b0;
            end else if (sd_wr_req) begin
                pend = 1'b1;
                p_addr = sd_wr_addr;
                p_data = sd_wr_data;
            end else begin
                pend = 1'b0;
            end
            if (blk_done) done_cnt++;
            if (sdram_rx_rdy) rx_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (sdram_rx_rdy !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) check(tag, 32'(sdram_rx_rdy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (blk_done !== 1'b1 && n < 5000) begin step(); n++; end
        if (n >= 5000) check(tag, 32'(blk_done), 32'd1);
    endtask

    task automatic send_block(input logic [15:0] d0);
        for (int i = 0; i <= WORDS; i++) begin
            step();
            fifo_rdreq = (i < WORDS);
            if (i > 0) fifo_q = d0 + 16'(i - 1);
        end
        step();
        fifo_q = '0;
    endtask

    task automatic check_block(input string tag, input int start,
                               input logic [ADDR_W-1:0] a0, input logic [15:0] d0);
        int bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (log_addr[start + i] !== a0 + ADDR_W'(i)) bad++;
            if (log_data[start + i] !== d0 + 16'(i)) bad++;
        end
        check({tag, "_count"}, 32'(wr_cnt - start), 32'(WORDS));
        check({tag, "_words"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int s;
        #1;
        check("rst_rx_rdy", 32'(sdram_rx_rdy), 32'd0);
        check("rst_req",    32'(sd_wr_req), 32'd0);
        check("rst_addr",   32'(sd_wr_addr), 32'd0);
        check("rst_data",   32'(sd_wr_data), 32'd0);
        check("rst_done",   32'(blk_done), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        check("idle_no_rx", 32'(rx_cnt), 32'd0);

        // Block 1: ack tied high, data 0..511 to addresses 0..511.
        s = wr_cnt;
        fifo_tx_rdy = 1'b1;
        wait_rx("b1_rx_timeout");
        fifo_tx_rdy = 1'b0;
        send_block(16'h0000);
        wait_done("b1_done_timeout");
        check_block("b1", s, 10'd0, 16'h0000);
        check("b1_rx_cnt", 32'(rx_cnt), 32'd1);
        step();
        check("b1_done_cnt", 32'(done_cnt), 32'd1);

        // Blocks 2 and 3: tx_rdy held high, random stalls on block 2, wrap on 3.
        ack_mode = 1;
        s = wr_cnt;
        fifo_tx_rdy = 1'b1;
        wait_rx("b2_rx_timeout");
        send_block(16'h1000);
        wait_done("b2_done_timeout");
        ack_mode = 0;
        check_block("b2", s, 10'd512, 16'h1000);
        check("b2_stable", 32'(stab_err), 32'd0);
        check("b2_rx_cnt", 32'(rx_cnt), 32'd2);
        step();
        check("b2b_rx_rdy", 32'(sdram_rx_rdy), 32'd1);
        fifo_tx_rdy = 1'b0;
        s = wr_cnt;
        send_block(16'h2000);
        wait_done("b3_done_timeout");
        check_block("b3_wrap", s, 10'd0, 16'h2000);
        check("b3_err", 32'(err), 32'd0);
        step();
        check("b3_rx_cnt", 32'(rx_cnt), 32'd3);
        check("b3_done_cnt", 32'(done_cnt), 32'd3);

        // Block 4 at base 512, reset at word 300 of the write phase.
        s = wr_cnt;
        fifo_tx_rdy = 1'b1;
        wait_rx("b4_rx_timeout");
        fifo_tx_rdy = 1'b0;
        send_block(16'h3000);
        begin
            int n = 0;
            while (wr_cnt < s + 300 && n < 2000) begin step(); n++; end
            check("b4_reach_300", 32'(wr_cnt - s), 32'd300);
        end
        check("b4_mid_addr", 32'(sd_wr_addr >= 10'd512), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req",  32'(sd_wr_req), 32'd0);
        check("arst_addr", 32'(sd_wr_addr), 32'd0);
        check("arst_data", 32'(sd_wr_data), 32'd0);
        check("arst_done", 32'(blk_done), 32'd0);
        check("arst_rx",   32'(sdram_rx_rdy), 32'd0);
        check("arst_err",  32'(err), 32'd0);
        s = wr_cnt;
        repeat (3) step();
        rst = 1'b0;
        repeat (50) step();
        check("abort_no_writes", 32'(wr_cnt - s), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd3);

        // Block 5 from address 0, with an overrun strobe injected mid-write.
        s = wr_cnt;
        fifo_tx_rdy = 1'b1;
        wait_rx("b5_rx_timeout");
        fifo_tx_rdy = 1'b0;
        send_block(16'h5000);
        repeat (5) step();
        check("b5_err_pre", 32'(err), 32'd0);
        fifo_rdreq = 1'b1;
        fifo_q = 16'hDEAD;
        step();
        fifo_rdreq = 1'b0;
        step();
        fifo_q = 16'hBEEF;
        repeat (2) step();
        fifo_q = '0;
        check("b5_err_set", 32'(err), 32'd1);
        wait_done("b5_done_timeout");
        check_block("b5", s, 10'd0, 16'h5000);
        repeat (20) step();
        check("b5_err_sticky", 32'(err), 32'd1);
        check("b5_rx_cnt", 32'(rx_cnt), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
